btn_pulse_repeater: RTL and testbench

//   Sits directly downstream of the button debouncer, one instance per meter button (coin/add-time/mode).

---
 rtl/btn_pulse_repeater_pkg.sv | 15 +
 rtl/btn_pulse_repeater.sv | 124 ++++++++++++
 tb/tb_btn_pulse_repeater.sv | 138 +++++++++++++
 3 files changed

// File: rtl/btn_pulse_repeater_pkg.sv
// rtl/btn_pulse_repeater_pkg.sv - shared state encodings and widths for btn_pulse_repeater
package btn_pulse_repeater_pkg;

  // FSM state encodings
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  // Repeat counter width and its saturation value
  localparam int RPT_CNT_W = 8;
  localparam logic [RPT_CNT_W-1:0] RPT_CNT_MAX = {RPT_CNT_W{1'b1}};

endpackage

// File: rtl/btn_pulse_repeater.sv
// rtl/btn_pulse_repeater.sv - press/release/auto-repeat pulse generator (optional accel: BTN_REPEAT_ACCEL_EN)
module btn_pulse_repeater
  import btn_pulse_repeater_pkg::*;
#(
  parameter int CNT_W         = 24,
  parameter int HOLD_DELAY    = 10,
  parameter int REPEAT_PERIOD = 4,
  parameter int ACCEL_AFTER   = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level_in,
  input  logic en,
  output logic press_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic held
);

  // Halved period once accelerated, never below one cycle
  localparam int ACCEL_PERIOD = ((REPEAT_PERIOD >> 1) < 1) ? 1 : (REPEAT_PERIOD >> 1);

`ifdef BTN_REPEAT_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RPT_CNT_W-1:0]   rpt_cnt_q, rpt_cnt_d;
  logic                   level_q;
  logic                   press_q, press_d;
  logic                   repeat_q, repeat_d;
  logic                   release_q, release_d;
  logic                   held_q;

  logic                   rise;
  logic [CNT_W-1:0]       period_m1;
  logic [CNT_W-1:0]       term_cnt;

  assign rise = level_in & ~level_q;

  // Repeat interval shortens once enough repeats have gone out (only when accel is built in)
  assign period_m1 = (ACCEL_ON && (rpt_cnt_q >= RPT_CNT_W'(ACCEL_AFTER)))
                   ? CNT_W'(ACCEL_PERIOD - 1)
                   : CNT_W'(REPEAT_PERIOD - 1);

  assign term_cnt = (state_q == ST_DELAY) ? CNT_W'(HOLD_DELAY - 1) : period_m1;

  // Next-state and pulse decode; disable beats release, release beats a terminal count
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpt_cnt_d = rpt_cnt_q;
    press_d   = 1'b0;
    repeat_d  = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise && en) begin
          state_d = ST_DELAY;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (!en) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          rpt_cnt_d = '0;
        end else if (!level_in) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          rpt_cnt_d = '0;
          release_d = 1'b1;
        end else if (cnt_q == term_cnt) begin
          state_d  = ST_REPEAT;
          cnt_d    = '0;
          repeat_d = 1'b1;
          if (rpt_cnt_q != RPT_CNT_MAX) begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        rpt_cnt_d = '0;
      end
    endcase
  end

  // State, counters and registered outputs; held tracks the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rpt_cnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      repeat_q  <= 1'b0;
      release_q <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rpt_cnt_q <= rpt_cnt_d;
      level_q   <= level_in;
      press_q   <= press_d;
      repeat_q  <= repeat_d;
      release_q <= release_d;
      held_q    <= (state_d != ST_IDLE);
    end
  end

  assign press_pulse   = press_q;
  assign repeat_pulse  = repeat_q;
  assign release_pulse = release_q;
  assign held          = held_q;

endmodule

// File: tb/tb_btn_pulse_repeater.sv
// tb/tb_btn_pulse_repeater.sv - directed table-driven bench for btn_pulse_repeater
module tb_btn_pulse_repeater;

  logic clk = 1'b0;
  logic rst_n;
  logic level_in;
  logic en;
  logic press_pulse, repeat_pulse, release_pulse, held;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       lvl;
    logic       en;
    logic [3:0] exp;   // {press, repeat, release, held}
    string      name;
  } vec_t;

  vec_t tbl[$];

  btn_pulse_repeater #(
    .CNT_W(24), .HOLD_DELAY(10), .REPEAT_PERIOD(4), .ACCEL_AFTER(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .level_in(level_in), .en(en),
    .press_pulse(press_pulse), .repeat_pulse(repeat_pulse),
    .release_pulse(release_pulse), .held(held)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic l, input logic e, input logic [3:0] x, input string n);
    vec_t v;
    v.lvl = l; v.en = e; v.exp = x; v.name = n;
    tbl.push_back(v);
  endfunction

  function automatic logic is_rep(input int k);
`ifdef BTN_REPEAT_ACCEL_EN
    return (k == 10 || k == 14 || k == 18 || k == 20 || k == 22 || k == 24 || k == 26 || k == 28);
`else
    return (k == 10 || k == 14 || k == 18 || k == 22 || k == 26);
`endif
  endfunction

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {press_pulse, repeat_pulse, release_pulse, held};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got press/rep/rel/held=%b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic l, input logic e);
    @(negedge clk);
    level_in = l;
    en       = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    level_in = 1'b0;
    en       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: short press
    add(0, 1, 4'b0000, "t1_idle");
    add(1, 1, 4'b1001, "t1_press");
    for (int i = 0; i < 4; i++) add(1, 1, 4'b0001, "t1_hold");
    add(0, 1, 4'b0010, "t1_release");
    add(0, 1, 4'b0000, "t1_after");

    // 2/3: 30-cycle hold, repeat times depend on accel build
    for (int k = 0; k <= 30; k++) begin
      add(k < 30, 1, {k == 0, is_rep(k), k == 30, k < 30}, "t2_hold30");
    end
    add(0, 1, 4'b0000, "t2_after");

    // 4: fall on terminal delay count, then immediate re-press
    add(1, 1, 4'b1001, "t4_press");
    for (int i = 0; i < 9; i++) add(1, 1, 4'b0001, "t4_delay");
    add(0, 1, 4'b0010, "t4_release_wins");
    add(1, 1, 4'b1001, "t4_repress");
    add(0, 1, 4'b0010, "t4_release2");
    add(0, 1, 4'b0000, "t4_after");

    // 5: enable gating
    add(1, 0, 4'b0000, "t5_press_disabled");
    add(1, 1, 4'b0000, "t5_en_rise_held");
    add(1, 1, 4'b0000, "t5_still_no_press");
    add(0, 1, 4'b0000, "t5_let_go");
    add(1, 1, 4'b1001, "t5_press");
    for (int k = 1; k <= 11; k++) add(1, 1, (k == 10) ? 4'b0101 : 4'b0001, "t5_hold");
    add(1, 0, 4'b0000, "t5_en_drop");
    add(1, 0, 4'b0000, "t5_disabled");
    add(1, 1, 4'b0000, "t5_reenable_held");
    add(0, 1, 4'b0000, "t5_fall_idle");

    foreach (tbl[i]) begin
      step(tbl[i].lvl, tbl[i].en);
      check(tbl[i].name, tbl[i].exp);
    end

    // 6: async reset mid-REPEAT with the button still held
    step(1, 1);
    check("t6_press", 4'b1001);
    for (int k = 1; k <= 12; k++) step(1, 1);
    check("t6_in_repeat", 4'b0001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", 4'b0000);
    @(posedge clk);
    #1;
    check("t6_in_reset", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_press_after_reset", 4'b1001);
    step(1, 1);
    check("t6_single_press", 4'b0001);
    step(0, 1);
    check("t6_release", 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
